signal_patch_ctrl: RTL

- Parametrised observe/control patch unit: watches an observe bus for a programmable masked pattern and, once triggered, overrides NUM_CH controlled signal lanes.
- Each lane can be forced to 0, forced to 1, inverted or passed through on selected bits.
- Sits between original logic and its consumers, generalising the fixed per-bit observe/control points to run-time configurable, counted triggers.

---
 rtl/patch_pkg.sv | 10 +
 rtl/patch_lane.sv | 18 +
 rtl/signal_patch_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/patch_pkg.sv
// patch_pkg: shared state/lane-mode types and register map for the signal patch unit
package patch_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} state_e;
    typedef enum logic [1:0] {PASS, FORCE0, FORCE1, INVERT} lane_mode_e;
    localparam int ADDR_MATCH_VAL  = 0;
    localparam int ADDR_MATCH_MASK = 1;
    localparam int ADDR_MATCH_CNT  = 2;
    localparam int ADDR_HOLD_CNT   = 3;
    localparam int ADDR_LANE_BASE  = 4;
endpackage

// File: rtl/patch_lane.sv
// patch_lane: combinational per-bit override of one controlled lane
module patch_lane
    import patch_pkg::*;
#(
    parameter int CH_W = 2
) (
    input  logic            active,
    input  lane_mode_e      mode,
    input  logic [CH_W-1:0] mask,
    input  logic [CH_W-1:0] in,
    output logic [CH_W-1:0] out
);
    logic [CH_W-1:0] ovr;
    always_comb begin
        ovr = mode == FORCE0 ? '0 : mode == FORCE1 ? '1 : mode == INVERT ? ~in : in;
        out = active ? (in & ~mask) | (ovr & mask) : in;
    end
endmodule

// File: rtl/signal_patch_ctrl.sv
// signal_patch_ctrl: counted masked-pattern trigger that overrides NUM_CH signal lanes
module signal_patch_ctrl
    import patch_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int OBS_W  = 8,
    parameter int CNT_W  = 16,
    localparam int ADDR_W = $clog2(4 + NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [31:0]              cfg_wdata,
    output logic                     cfg_err,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic [OBS_W-1:0]         obs_in,
    input  logic [NUM_CH*CH_W-1:0]   sig_in,
    output logic [NUM_CH*CH_W-1:0]   sig_out,
    output logic [1:0]               state_o,
    output logic                     trig_active,
    output logic [7:0]               fire_cnt
);
    state_e           state_q, state_d;
    logic [OBS_W-1:0] val_q, val_d, mask_q, mask_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d, hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d, hcnt_q, hcnt_d, target;
    lane_mode_e       mode_q [NUM_CH], mode_d [NUM_CH];
    logic [CH_W-1:0]  lmask_q [NUM_CH], lmask_d [NUM_CH];
    logic [7:0]       fire_q, fire_d;
    logic             err_q, err_d, wr_ok, match, cfg_unused;
    assign cfg_unused = ^cfg_wdata;
    always_comb begin
        wr_ok       = cfg_we && state_q == IDLE && int'(cfg_addr) < ADDR_LANE_BASE + NUM_CH;
        err_d       = cfg_we && !wr_ok;
        val_d       = wr_ok && int'(cfg_addr) == ADDR_MATCH_VAL  ? cfg_wdata[OBS_W-1:0] : val_q;
        mask_d      = wr_ok && int'(cfg_addr) == ADDR_MATCH_MASK ? cfg_wdata[OBS_W-1:0] : mask_q;
        match_cnt_d = wr_ok && int'(cfg_addr) == ADDR_MATCH_CNT  ? cfg_wdata[CNT_W-1:0] : match_cnt_q;
        hold_cnt_d  = wr_ok && int'(cfg_addr) == ADDR_HOLD_CNT   ? cfg_wdata[CNT_W-1:0] : hold_cnt_q;
        for (int k = 0; k < NUM_CH; k++) begin
            mode_d[k]  = wr_ok && int'(cfg_addr) == ADDR_LANE_BASE + k ? lane_mode_e'(cfg_wdata[CH_W+1:CH_W]) : mode_q[k];
            lmask_d[k] = wr_ok && int'(cfg_addr) == ADDR_LANE_BASE + k ? cfg_wdata[CH_W-1:0] : lmask_q[k];
        end
    end
    always_comb begin
        target  = match_cnt_q == '0 ? CNT_W'(1) : match_cnt_q;
        match   = ((obs_in ^ val_q) & mask_q) == '0;
        state_d = state_q;
        mcnt_d  = mcnt_q;
        hcnt_d  = hcnt_q;
        fire_d  = fire_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    mcnt_d  = '0;
                end
            end
            ARMED: begin
                mcnt_d = match ? mcnt_q + CNT_W'(1) : '0;
                if (match && mcnt_q + CNT_W'(1) == target) begin
                    state_d = ACTIVE;
                    hcnt_d  = CNT_W'(1);
                    fire_d  = fire_q == 8'hFF ? fire_q : fire_q + 8'd1;
                end
            end
            ACTIVE: begin
                hcnt_d = &hcnt_q ? hcnt_q : hcnt_q + CNT_W'(1);
                if (hold_cnt_q != '0 && hcnt_q >= hold_cnt_q) state_d = DONE;
            end
            default: ;
        endcase
        if (disarm) begin
            state_d = IDLE;
            fire_d  = fire_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            val_q       <= '0;
            mask_q      <= '0;
            match_cnt_q <= '0;
            hold_cnt_q  <= '0;
            mcnt_q      <= '0;
            hcnt_q      <= '0;
            fire_q      <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                mode_q[k]  <= PASS;
                lmask_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            mask_q      <= mask_d;
            match_cnt_q <= match_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            mcnt_q      <= mcnt_d;
            hcnt_q      <= hcnt_d;
            fire_q      <= fire_d;
            err_q       <= err_d;
            for (int k = 0; k < NUM_CH; k++) begin
                mode_q[k]  <= mode_d[k];
                lmask_q[k] <= lmask_d[k];
            end
        end
    end
    assign state_o     = state_q;
    assign trig_active = state_q == ACTIVE;
    assign fire_cnt    = fire_q;
    assign cfg_err     = err_q;
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        patch_lane #(.CH_W(CH_W)) u_lane (
            .active (trig_active),
            .mode   (mode_q[k]),
            .mask   (lmask_q[k]),
            .in     (sig_in[k*CH_W +: CH_W]),
            .out    (sig_out[k*CH_W +: CH_W])
        );
    end
endmodule
